// File: rtl/reset_pkg.sv
// reset_pkg: shared sequencer state and reset-cause encodings for reset_sequencer.
package reset_pkg;
  typedef enum logic [1:0] {SEQ_HOLD, SEQ_RELEASE, SEQ_RUN} seqState_t;
  typedef enum logic [1:0] {CAUSE_POR = 2'b01, CAUSE_SW = 2'b10, CAUSE_WDT = 2'b11} resetCause_t;
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/reset_watchdog.sv
// reset_watchdog: free-running RUN-state watchdog; expire fires when the counter saturates unkicked.
module reset_watchdog #(
  parameter int WDT_WIDTH = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expire
);
  logic [WDT_WIDTH-1:0] wdt_q;
  always_ff @(posedge clk) begin
    if (reset || !run || kick) wdt_q <= '0;
    else wdt_q <= wdt_q + 1'b1;
  end
  assign expire = run && !kick && (wdt_q == '1);
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds STAGES resets, then releases them in index order with a fixed gap.
// Optional watchdog restart is enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_DELAY = 16,
  parameter int WDT_WIDTH   = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              swResetReq,
  input  logic              wdtKick,
  output logic [STAGES-1:0] resetOut,
  output logic              ready,
  output logic [1:0]        resetCause
);
  localparam int CW = $clog2(max_u(HOLD_CYCLES, STAGE_DELAY) + 1);
  localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
  seqState_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  logic [STAGES-1:0] out_q;
  logic              ready_q;
  resetCause_t       cause_q;
  logic              expire;
`ifdef RESET_SEQ_WATCHDOG_EN
  reset_watchdog #(.WDT_WIDTH(WDT_WIDTH)) u_wdt (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == SEQ_RUN),
    .kick  (wdtKick),
    .expire(expire)
  );
`else
  logic [WDT_WIDTH-1:0] unused_wdt;
  assign unused_wdt = {WDT_WIDTH{wdtKick}};
  assign expire = 1'b0;
`endif
  // Restart request wins over watchdog expiry on the same cycle.
  always_ff @(posedge clk) begin
    if (reset || swResetReq || expire) begin
      state_q <= SEQ_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= reset ? CAUSE_POR : swResetReq ? CAUSE_SW : CAUSE_WDT;
    end else if (state_q == SEQ_HOLD) begin
      cnt_q <= cnt_q == CW'(HOLD_CYCLES - 1) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        state_q <= SEQ_RELEASE;
        idx_q   <= '0;
      end
    end else if (state_q == SEQ_RELEASE) begin
      cnt_q <= cnt_q == CW'(STAGE_DELAY - 1) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CW'(STAGE_DELAY - 1)) begin
        out_q <= out_q << 1;
        if (idx_q == IW'(STAGES - 1)) begin
          state_q <= SEQ_RUN;
          ready_q <= 1'b1;
        end else idx_q <= idx_q + 1'b1;
      end
    end
  end
  assign resetOut   = out_q;
  assign ready      = ready_q;
  assign resetCause = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of two sequencer builds against an elapsed-edge model.
module tb_reset_sequencer;
  localparam int WMAX = 255;
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sw = 1'b0, kick = 1'b0;
  logic [3:0] out0;
  logic rdy0, out1, rdy1;
  logic [1:0] cs0, cs1;
  int compared = 0, mismatched = 0;
  int e[2] = '{0, 0}, w[2] = '{0, 0}, cz[2] = '{1, 1};
  bit rp[2] = '{1'b0, 1'b0};
  int hh[2] = '{64, 1}, dd[2] = '{16, 1}, ss[2] = '{4, 1};

  always #5 clk = ~clk;

  reset_sequencer #(.STAGES(4), .HOLD_CYCLES(64), .STAGE_DELAY(16), .WDT_WIDTH(8)) dut0 (
    .clk(clk), .reset(rst), .swResetReq(sw), .wdtKick(kick),
    .resetOut(out0), .ready(rdy0), .resetCause(cs0));
  reset_sequencer #(.STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1), .WDT_WIDTH(8)) dut1 (
    .clk(clk), .reset(rst), .swResetReq(sw), .wdtKick(kick),
    .resetOut(out1), .ready(rdy1), .resetCause(cs1));

  // Stages released so far, from edges elapsed since the last (re)start.
  function automatic int rel(input int m);
    int r;
    if (e[m] < hh[m]) return 0;
    r = (e[m] - hh[m]) / dd[m];
    return r > ss[m] ? ss[m] : r;
  endfunction
  function automatic logic [3:0] x0();
    logic [3:0] v;
    v = 4'hF << rel(0);
    return v;
  endfunction
  function automatic logic x1();
    return rel(1) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      bit fire;
      fire = WDT_ON && rp[m] && !kick && w[m] == WMAX;
      if (rst) begin e[m] = 0; cz[m] = 1; w[m] = 0; end
      else if (sw) begin e[m] = 0; cz[m] = 2; w[m] = 0; end
      else if (fire) begin e[m] = 0; cz[m] = 3; w[m] = 0; end
      else begin
        e[m] = e[m] < 100000 ? e[m] + 1 : e[m];
        w[m] = rp[m] ? (kick ? 0 : w[m] + 1) : 0;
      end
      rp[m] = rel(m) == ss[m];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) tick();
    if (out0 !== 4'hF || rdy0 !== 1'b0 || cs0 !== 2'b01) begin
      mismatched++;
      $display("FAIL reset dut0 got out=%b rdy=%b cause=%b want out=1111 rdy=0 cause=01", out0, rdy0, cs0);
    end
    compared++;
    if (out1 !== 1'b1 || rdy1 !== 1'b0 || cs1 !== 2'b01) begin
      mismatched++;
      $display("FAIL reset dut1 got out=%b rdy=%b cause=%b want out=1 rdy=0 cause=01", out1, rdy1, cs1);
    end
    compared++;
  endtask

  task automatic test_por();
    rst = 1'b0;
    for (int n = 1; n <= 140; n++) begin
      kick = WDT_ON ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      if (out0 !== x0() || rdy0 !== (rel(0) == 4) || cs0 !== 2'(cz[0])) begin
        mismatched++;
        $display("FAIL por dut0 n=%0d got out=%b rdy=%b cause=%b want out=%b rdy=%b cause=%0d",
                 n, out0, rdy0, cs0, x0(), rel(0) == 4, cz[0]);
      end
      compared++;
      if (out1 !== x1() || rdy1 !== (rel(1) == 1) || cs1 !== 2'(cz[1])) begin
        mismatched++;
        $display("FAIL por dut1 n=%0d got out=%b rdy=%b cause=%b want out=%b rdy=%b cause=%0d",
                 n, out1, rdy1, cs1, x1(), rel(1) == 1, cz[1]);
      end
      compared++;
      if ((n == 79 && out0 !== 4'hF) || (n == 80 && out0 !== 4'hE) || (n == 96 && out0 !== 4'hC) ||
          (n == 112 && out0 !== 4'h8) || (n == 128 && (out0 !== 4'h0 || rdy0 !== 1'b1)) ||
          (n == 2 && (out1 !== 1'b0 || rdy1 !== 1'b1))) begin
        mismatched++;
        $display("FAIL por_edge n=%0d got out0=%b rdy0=%b out1=%b rdy1=%b", n, out0, rdy0, out1, rdy1);
      end
      if (n == 2 || n == 79 || n == 80 || n == 96 || n == 112 || n == 128) compared++;
    end
    kick = 1'b0;
  endtask

  task automatic test_sw();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    if (out0 !== 4'hF || rdy0 !== 1'b0 || cs0 !== 2'b10) begin
      mismatched++;
      $display("FAIL sw_run got out=%b rdy=%b cause=%b want out=1111 rdy=0 cause=10", out0, rdy0, cs0);
    end
    compared++;
    for (int n = 1; n <= 130; n++) begin
      sw = n == 100 ? 1'b1 : 1'b0;
      tick();
      if (out0 !== x0() || rdy0 !== (rel(0) == 4) || cs0 !== 2'(cz[0])) begin
        mismatched++;
        $display("FAIL sw_seq n=%0d got out=%b rdy=%b cause=%b want out=%b cause=%0d", n, out0, rdy0, cs0, x0(), cz[0]);
      end
      compared++;
    end
    sw = 1'b1;
    tick();
    sw = 1'b0;
    repeat (99) tick();
    sw = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (out0 !== 4'hF || cs0 !== 2'b10) begin
        mismatched++;
        $display("FAIL sw_held n=%0d got out=%b cause=%b want out=1111 cause=10", n, out0, cs0);
      end
      compared++;
    end
    sw = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (out0 !== x0() || rdy0 !== (rel(0) == 4) || out1 !== x1()) begin
        mismatched++;
        $display("FAIL sw_drop n=%0d got out0=%b rdy0=%b out1=%b want out0=%b out1=%b", n, out0, rdy0, out1, x0(), x1());
      end
      compared++;
      if (n == 80 && out0 !== 4'hE) begin
        mismatched++;
        $display("FAIL sw_drop_first got %b want 1110", out0);
      end
      if (n == 80) compared++;
    end
  endtask

  task automatic test_reset_mid();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    repeat (89) tick();
    rst = 1'b1;
    tick();
    if (out0 !== 4'hF || rdy0 !== 1'b0 || cs0 !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_mid got out=%b rdy=%b cause=%b want out=1111 rdy=0 cause=01", out0, rdy0, cs0);
    end
    compared++;
    repeat (3) tick();
    rst = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (out0 !== x0() || rdy0 !== (rel(0) == 4) || cs0 !== 2'(cz[0])) begin
        mismatched++;
        $display("FAIL reset_mid_seq n=%0d got out=%b rdy=%b cause=%b want out=%b cause=%0d", n, out0, rdy0, cs0, x0(), cz[0]);
      end
      compared++;
    end
  endtask

`ifdef RESET_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    repeat (128) tick();
    for (int n = 1; n <= 256; n++) begin
      tick();
      if ((n < 256 && rdy0 !== 1'b1) || (n == 256 && (rdy0 !== 1'b0 || cs0 !== 2'b11 || cs1 !== 2'b11))) begin
        mismatched++;
        $display("FAIL wdt_expire n=%0d got rdy=%b cause0=%b cause1=%b", n, rdy0, cs0, cs1);
      end
      compared++;
    end
    repeat (128) tick();
    for (int n = 1; n <= 5000; n++) begin
      kick = n % 200 == 0;
      tick();
      if (rdy0 !== 1'b1 || cs0 !== 2'b11) begin
        mismatched++;
        $display("FAIL wdt_kicked n=%0d got rdy=%b cause=%b want rdy=1 cause=11", n, rdy0, cs0);
      end
      compared++;
    end
    kick = 1'b1;
    tick();
    kick = 1'b0;
    repeat (255) tick();
    kick = 1'b1;
    tick();
    kick = 1'b0;
    if (rdy0 !== 1'b1 || cs0 !== 2'b11) begin
      mismatched++;
      $display("FAIL wdt_kick_on_expiry got rdy=%b cause=%b want rdy=1 cause=11", rdy0, cs0);
    end
    compared++;
    repeat (255) tick();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    if (rdy0 !== 1'b0 || cs0 !== 2'b10) begin
      mismatched++;
      $display("FAIL wdt_sw_same_cycle got rdy=%b cause=%b want rdy=0 cause=10", rdy0, cs0);
    end
    compared++;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      sw   = $urandom_range(0, 249) == 0;
      rst  = $urandom_range(0, 699) == 0;
      kick = WDT_ON ? $urandom_range(0, 299) == 0 : 1'($urandom_range(0, 1));
      tick();
      if (out0 !== x0() || rdy0 !== (rel(0) == 4) || cs0 !== 2'(cz[0])) begin
        mismatched++;
        $display("FAIL random dut0 n=%0d got out=%b rdy=%b cause=%b want out=%b rdy=%b cause=%0d",
                 n, out0, rdy0, cs0, x0(), rel(0) == 4, cz[0]);
      end
      compared++;
      if (out1 !== x1() || rdy1 !== (rel(1) == 1) || cs1 !== 2'(cz[1])) begin
        mismatched++;
        $display("FAIL random dut1 n=%0d got out=%b rdy=%b cause=%b want out=%b rdy=%b cause=%0d",
                 n, out1, rdy1, cs1, x1(), rel(1) == 1, cz[1]);
      end
      compared++;
    end
    rst = 1'b0;
    sw = 1'b0;
    kick = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_por();
    test_sw();
    test_reset_mid();
`ifdef RESET_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
